multi_edge_detector: RTL and testbench

- Parametrised, multi-channel edge detector; next generation of the single-bit rising-edge detector.
- Per channel: input synchroniser, glitch filter, per-channel rising/falling/both edge selection, one-cycle event pulse, sticky event flag with clear, and saturating event counter.
- Sits between asynchronous external/status inputs and the control/interrupt logic in the same clock domain.

---
 rtl/multi_edge_detector.sv | 143 ++++++++++++++
 tb/tb_multi_edge_detector.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_edge_detector.sv
// multi_edge_detector
//   Multi-channel edge detector. Each channel synchronises an asynchronous
//   input, debounces it with a stability filter, and then detects rising
//   and/or falling edges of the filtered level. Each accepted edge produces
//   a one-cycle pulse, sets a sticky flag and bumps a saturating counter.
//
// Ports
//   clk        single clock, all state on rising edge
//   resetn     asynchronous active-low reset
//   data_in    [N_CH]        raw (possibly asynchronous) inputs
//   rise_en    [N_CH]        enable rising-edge events per channel
//   fall_en    [N_CH]        enable falling-edge events per channel
//   clr        [N_CH]        sticky-flag clear pulse
//   cnt_clr    [N_CH]        counter clear pulse
//   pulse_out  [N_CH]        one-cycle event pulse
//   sticky     [N_CH]        latched event flag
//   event_cnt  [N_CH*CNT_W]  saturating counters, channel i at [i*CNT_W +: CNT_W]
//   any_event               OR of all sticky flags

module multi_edge_detector_lane #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             din,
  input  logic             rise_en,
  input  logic             fall_en,
  input  logic             clr,
  input  logic             cnt_clr,
  output logic             pulse,
  output logic             sticky,
  output logic [CNT_W-1:0] cnt
);
  localparam int             SW       = $clog2(FILT_CYCLES) + 1;
  localparam logic [SW-1:0]  STAB_MAX = SW'(FILT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [SW-1:0]          stab;
  logic                   filt_level;
  logic                   filt_prev;
  logic                   rise;
  logic                   fall;
  logic                   ev;

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync <= '0;
    end else begin
      sync[0] <= din;
      for (int k = 1; k < SYNC_STAGES; k++) sync[k] <= sync[k-1];
    end
  end

  // Level is only accepted after FILT_CYCLES consecutive differing samples;
  // any sample matching the current level restarts the count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stab       <= '0;
      filt_level <= 1'b0;
      filt_prev  <= 1'b0;
    end else begin
      filt_prev <= filt_level;
      if (s == filt_level) begin
        stab <= '0;
      end else if (stab == STAB_MAX) begin
        filt_level <= s;
        stab       <= '0;
      end else begin
        stab <= stab + SW'(1);
      end
    end
  end

  assign rise = filt_level & ~filt_prev;
  assign fall = ~filt_level & filt_prev;
  assign ev   = (rise & rise_en) | (fall & fall_en);

  // An event coinciding with a clear wins: the flag stays set and the
  // counter restarts at 1 so the event is not lost.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pulse  <= 1'b0;
      sticky <= 1'b0;
      cnt    <= '0;
    end else begin
      pulse <= ev;
      if (ev)       sticky <= 1'b1;
      else if (clr) sticky <= 1'b0;
      if (ev) begin
        if (cnt_clr)             cnt <= CNT_W'(1);
        else if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
      end else if (cnt_clr) begin
        cnt <= '0;
      end
    end
  end
endmodule

module multi_edge_detector #(
  parameter int N_CH        = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [N_CH-1:0]       data_in,
  input  logic [N_CH-1:0]       rise_en,
  input  logic [N_CH-1:0]       fall_en,
  input  logic [N_CH-1:0]       clr,
  input  logic [N_CH-1:0]       cnt_clr,
  output logic [N_CH-1:0]       pulse_out,
  output logic [N_CH-1:0]       sticky,
  output logic [N_CH*CNT_W-1:0] event_cnt,
  output logic                  any_event
);
  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    multi_edge_detector_lane #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_CYCLES(FILT_CYCLES),
      .CNT_W      (CNT_W)
    ) u_lane (
      .clk    (clk),
      .resetn (resetn),
      .din    (data_in[i]),
      .rise_en(rise_en[i]),
      .fall_en(fall_en[i]),
      .clr    (clr[i]),
      .cnt_clr(cnt_clr[i]),
      .pulse  (pulse_out[i]),
      .sticky (sticky[i]),
      .cnt    (event_cnt[i*CNT_W +: CNT_W])
    );
  end

  assign any_event = |sticky;
endmodule

// File: tb/tb_multi_edge_detector.sv
module tb_multi_edge_detector;
  localparam int N = 8;
  localparam int W = 3;

  logic           clk = 1'b0;
  logic           resetn;
  logic [N-1:0]   data_in, rise_en, fall_en, clr, cnt_clr;
  logic [N-1:0]   pulse_out, sticky;
  logic [N*W-1:0] event_cnt;
  logic           any_event;

  multi_edge_detector #(.N_CH(N), .SYNC_STAGES(2), .FILT_CYCLES(4), .CNT_W(W)) dut (
    .clk(clk), .resetn(resetn), .data_in(data_in), .rise_en(rise_en),
    .fall_en(fall_en), .clr(clr), .cnt_clr(cnt_clr), .pulse_out(pulse_out),
    .sticky(sticky), .event_cnt(event_cnt), .any_event(any_event)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [N-1:0] mask; } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, want %0d (cyc %0d)", name, act, exp, cyc);
  endtask

  function automatic int cnt_of(input int ch);
    return int'(event_cnt[ch*W +: W]);
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Input changed just now (after negedge with count cyc): first sample at
  // the next edge, pulse visible 7 edges later with SYNC=2, FILT=4.
  task automatic expect_pulse(input logic [N-1:0] m);
    exp_t e;
    e.cyc  = cyc + 7;
    e.mask = m;
    sb.push_back(e);
  endtask

  // Monitor: consumes expected pulses whenever the DUT presents one.
  always @(negedge clk) begin
    if (resetn) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        total++;
        $display("FAIL pulse_missing: got none, want mask %0h at cyc %0d", sb[0].mask, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (pulse_out != '0) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL pulse_unexpected: got mask %0h at cyc %0d, want none", pulse_out, cyc);
        end else begin
          mon_e = sb.pop_front();
          check("pulse_cyc", cyc, mon_e.cyc);
          check("pulse_mask", int'(pulse_out), int'(mon_e.mask));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    resetn  = 1'b0;
    data_in = '0;
    rise_en = '1;
    fall_en = 8'h02;
    clr     = '0;
    cnt_clr = '0;
    tick(3);
    check("rst_pulse", int'(pulse_out), 0);
    check("rst_sticky", int'(sticky), 0);
    check("rst_cnt", int'(event_cnt), 0);
    check("rst_any", int'(any_event), 0);
    resetn = 1'b1;
    tick(3);

    // ch0 basic rising edge
    data_in[0] = 1'b1;
    expect_pulse(8'h01);
    tick(10);
    check("ch0_sticky", int'(sticky), 8'h01);
    check("ch0_cnt", cnt_of(0), 1);
    check("ch0_others_cnt", int'(event_cnt >> W), 0);
    check("ch0_any", int'(any_event), 1);

    // ch1 glitch of 3 samples is rejected
    tick;
    data_in[1] = 1'b1;
    tick(3);
    data_in[1] = 1'b0;
    tick(8);
    check("ch1_glitch_cnt", cnt_of(1), 0);
    check("ch1_glitch_sticky", int'(sticky[1]), 0);
    // 4-sample high accepted, then fall also reported
    data_in[1] = 1'b1;
    expect_pulse(8'h02);
    tick(4);
    data_in[1] = 1'b0;
    expect_pulse(8'h02);
    tick(10);
    check("ch1_cnt", cnt_of(1), 2);
    check("ch1_sticky", int'(sticky[1]), 1);

    // ch2 saturation at 7
    for (int k = 0; k < 9; k++) begin
      data_in[2] = 1'b1;
      expect_pulse(8'h04);
      tick(6);
      data_in[2] = 1'b0;
      tick(6);
    end
    tick(2);
    check("ch2_sat", cnt_of(2), 7);
    cnt_clr[2] = 1'b1;
    tick;
    cnt_clr[2] = 1'b0;
    tick;
    check("ch2_cnt_clr", cnt_of(2), 0);

    // ch3 clear coincident with event: set wins, counter becomes 1
    data_in[3] = 1'b1;
    expect_pulse(8'h08);
    tick(6);
    clr[3]     = 1'b1;
    cnt_clr[3] = 1'b1;
    tick;
    clr[3]     = 1'b0;
    cnt_clr[3] = 1'b0;
    check("ch3_sticky_setwins", int'(sticky[3]), 1);
    check("ch3_cnt_setwins", cnt_of(3), 1);
    tick(3);
    clr = '1;
    tick;
    clr = '0;
    tick;
    check("clr_sticky", int'(sticky), 0);
    check("clr_any", int'(any_event), 0);
    check("ch3_cnt_kept", cnt_of(3), 1);

    // ch4 disabled, then both polarities enabled
    rise_en[4] = 1'b0;
    fall_en[4] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      data_in[4] = 1'b1;
      tick(6);
      data_in[4] = 1'b0;
      tick(6);
    end
    tick(2);
    check("ch4_dis_cnt", cnt_of(4), 0);
    check("ch4_dis_sticky", int'(sticky[4]), 0);
    rise_en[4] = 1'b1;
    fall_en[4] = 1'b1;
    tick;
    data_in[4] = 1'b1;
    expect_pulse(8'h10);
    tick(6);
    data_in[4] = 1'b0;
    expect_pulse(8'h10);
    tick(10);
    check("ch4_en_cnt", cnt_of(4), 2);

    // asynchronous reset mid-operation
    data_in[5] = 1'b1;
    expect_pulse(8'h20);
    tick(9);
    check("ch5_cnt", cnt_of(5), 1);
    data_in[6] = 1'b1;
    tick(4);
    #2;
    resetn     = 1'b0;
    data_in[6] = 1'b0;
    #1;
    check("arst_pulse", int'(pulse_out), 0);
    check("arst_sticky", int'(sticky), 0);
    check("arst_cnt", int'(event_cnt), 0);
    check("arst_any", int'(any_event), 0);
    tick(2);
    // ch0, ch3, ch5 are held high through reset: one simultaneous rise
    resetn = 1'b1;
    expect_pulse(8'h29);
    tick(10);
    check("post_rst_sticky", int'(sticky), 8'h29);
    check("post_rst_cnt0", cnt_of(0), 1);
    check("post_rst_cnt5", cnt_of(5), 1);
    check("post_rst_cnt6", cnt_of(6), 0);

    tick(3);
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
